// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: owns the PC, single-outstanding imem handshake
// and presents one instruction/PC pair per fetch to the F/D register.
`ifndef kNOP
`define kNOP 32'h0000_0013
`endif

module fetch_unit #(
  parameter int              PC_W     = 32,
  parameter int              IW       = 32,
  parameter int              PC_INC   = 1,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            bubble,
  input  logic            flush,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [IW-1:0]   imem_rdata,
  output logic [IW-1:0]   instruction_o,
  output logic [PC_W-1:0] pc_o,
  output logic            IDLE_WAIT
);

  localparam logic [IW-1:0]   NOP = IW'(`kNOP);
  localparam logic [PC_W-1:0] INC = PC_W'(PC_INC);

  typedef enum logic [2:0] {
    RST_IDLE,
    FETCH,
    WAIT,
    DRAIN,
    HOLD
  } state_t;

  state_t          state, state_d;
  logic [PC_W-1:0] fetch_pc, fetch_pc_d;
  logic [IW-1:0]   inst_q, inst_d;
  logic [PC_W-1:0] pc_q, pc_d;

  logic advance;
  logic redir;

  assign advance   = ~stall & ~bubble;
  assign redir     = flush & redirect_valid;
  assign imem_addr = fetch_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RST_IDLE;
      fetch_pc <= RESET_PC;
      inst_q   <= NOP;
      pc_q     <= RESET_PC;
    end else begin
      state    <= state_d;
      fetch_pc <= fetch_pc_d;
      inst_q   <= inst_d;
      pc_q     <= pc_d;
    end
  end

  always_comb begin
    state_d       = state;
    fetch_pc_d    = fetch_pc;
    inst_d        = inst_q;
    pc_d          = pc_q;
    imem_req      = 1'b0;
    instruction_o = NOP;
    pc_o          = pc_q;
    IDLE_WAIT     = 1'b1;

    case (state)
      RST_IDLE: begin
        state_d = FETCH;
        if (redir) fetch_pc_d = redirect_pc;
      end

      FETCH: begin
        if (redir) begin
          fetch_pc_d = redirect_pc;
        end else begin
          imem_req = 1'b1;
          state_d  = WAIT;
        end
      end

      // A redirect without the response leaves a stale reply in flight, which DRAIN absorbs.
      WAIT: begin
        if (redir) begin
          fetch_pc_d = redirect_pc;
          state_d    = imem_rvalid ? FETCH : DRAIN;
        end else if (imem_rvalid) begin
          inst_d     = imem_rdata;
          pc_d       = fetch_pc;
          fetch_pc_d = fetch_pc + INC;
          state_d    = HOLD;
        end
      end

      DRAIN: begin
        if (redir) fetch_pc_d = redirect_pc;
        if (imem_rvalid) state_d = FETCH;
      end

      HOLD: begin
        instruction_o = inst_q;
        pc_o          = pc_q;
        IDLE_WAIT     = 1'b0;
        if (redir) begin
          fetch_pc_d = redirect_pc;
          inst_d     = NOP;
          state_d    = FETCH;
        end else if (advance) begin
          imem_req = 1'b1;
          state_d  = WAIT;
        end
      end

      default: state_d = RST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed and randomized self-checking bench for fetch_unit,
// with a latency-programmable instruction memory and a PC-stream reference model.
`ifndef kNOP
`define kNOP 32'h0000_0013
`endif

module tb_fetch_unit;

  localparam logic [31:0] NOP = `kNOP;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        bubble = 1'b0;
  logic        flush = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instruction_o;
  logic [31:0] pc_o;
  logic        IDLE_WAIT;

  fetch_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .bubble        (bubble),
    .flush         (flush),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .instruction_o (instruction_o),
    .pc_o          (pc_o),
    .IDLE_WAIT     (IDLE_WAIT)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  // memory model state and per-cycle samples
  bit          pend = 1'b0;
  logic [31:0] paddr = '0;
  int          wcnt = 0;
  int          lat = 1;
  bit          o_req, o_iw, o_rv, o_overlap;
  logic [31:0] o_addr, o_inst, o_pc;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
  endfunction

  // Called at a negedge with this cycle's inputs already set; returns at the next negedge.
  task automatic cycle();
    imem_rvalid = pend && (wcnt == 0);
    imem_rdata  = imem_rvalid ? memf(paddr) : $urandom;
    #1;
    o_req     = imem_req;
    o_addr    = imem_addr;
    o_inst    = instruction_o;
    o_pc      = pc_o;
    o_iw      = IDLE_WAIT;
    o_rv      = imem_rvalid;
    o_overlap = imem_req && pend;
    if (imem_rvalid) pend = 1'b0;
    else if (pend) wcnt--;
    if (imem_req) begin
      pend  = 1'b1;
      paddr = imem_addr;
      wcnt  = lat - 1;
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0; stall = 1'b0; bubble = 1'b0;
    flush = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    for (int i = 0; i < n; i++) cycle();
    rst_n = 1'b1;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      cycle();
      ok = o_req;
    end
  endtask

  task automatic set_redir(input logic [31:0] target);
    flush = 1'b1; redirect_valid = 1'b1; redirect_pc = target;
  endtask

  task automatic clr_redir();
    flush = 1'b0; redirect_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] e_addr, e_pc;
    bit e_req, e_iw;
    lat = 1;
    rst_n = 1'b0;
    cycle();
    cycle();
    n_checks++; if (o_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %0b want 0", o_req); end
    n_checks++; if (o_iw !== 1'b1) begin n_fail++; $display("FAIL reset_idle_wait: got %0b want 1", o_iw); end
    n_checks++; if (o_inst !== NOP) begin n_fail++; $display("FAIL reset_inst: got %h want %h", o_inst, NOP); end
    n_checks++; if (o_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", o_pc); end
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      cycle();
      e_req  = (c % 2 == 1);
      e_addr = 32'((c - 1) / 2);
      e_iw   = !(c >= 3 && c % 2 == 1);
      e_pc   = (c < 3) ? 32'h0 : 32'((c - 3) / 2);
      n_checks++; if (o_req !== e_req) begin n_fail++; $display("FAIL seq_req c%0d: got %0b want %0b", c, o_req, e_req); end
      if (e_req) begin
        n_checks++; if (o_addr !== e_addr) begin n_fail++; $display("FAIL seq_addr c%0d: got %h want %h", c, o_addr, e_addr); end
      end
      n_checks++; if (o_iw !== e_iw) begin n_fail++; $display("FAIL seq_idle_wait c%0d: got %0b want %0b", c, o_iw, e_iw); end
      n_checks++; if (o_pc !== e_pc) begin n_fail++; $display("FAIL seq_pc c%0d: got %h want %h", c, o_pc, e_pc); end
      n_checks++; if (o_inst !== (e_iw ? NOP : memf(e_pc))) begin n_fail++; $display("FAIL seq_inst c%0d: got %h want %h", c, o_inst, e_iw ? NOP : memf(e_pc)); end
    end
  endtask

  task automatic test_stall();
    bit found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      cycle();
      found = o_req && (o_addr == 32'd5);
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL stall_reach: got no request for addr 5 want one"); end
    cycle();
    for (int i = 0; i < 5; i++) begin
      stall  = (i < 4);
      bubble = (i == 4);
      cycle();
      n_checks++; if (o_iw !== 1'b0 || o_pc !== 32'd5) begin n_fail++; $display("FAIL stall_hold_pc i%0d: got iw=%0b pc=%h want iw=0 pc=5", i, o_iw, o_pc); end
      n_checks++; if (o_inst !== memf(32'd5)) begin n_fail++; $display("FAIL stall_hold_inst i%0d: got %h want %h", i, o_inst, memf(32'd5)); end
      n_checks++; if (o_req !== 1'b0) begin n_fail++; $display("FAIL stall_no_req i%0d: got %0b want 0", i, o_req); end
    end
    stall = 1'b0; bubble = 1'b0;
    cycle();
    n_checks++; if (o_req !== 1'b1 || o_addr !== 32'd6) begin n_fail++; $display("FAIL stall_release: got req=%0b addr=%h want req=1 addr=6", o_req, o_addr); end
  endtask

  task automatic test_redirect_wait();
    bit ok;
    lat = 3;
    wait_req(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rwait_reach: got no request want one"); end
    lat = 1;
    set_redir(32'h40);
    cycle();
    clr_redir();
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (o_iw !== 1'b1 || o_inst !== NOP || o_req !== 1'b0) begin
        n_fail++; $display("FAIL rwait_drain i%0d: got iw=%0b inst=%h req=%0b want 1 %h 0", i, o_iw, o_inst, o_req, NOP);
      end
      if (i < 2) cycle();
    end
    n_checks++; if (!o_rv) begin n_fail++; $display("FAIL rwait_stale_timing: got rvalid=%0b want 1", o_rv); end
    cycle();
    n_checks++; if (o_req !== 1'b1 || o_addr !== 32'h40) begin n_fail++; $display("FAIL rwait_refetch: got req=%0b addr=%h want req=1 addr=40", o_req, o_addr); end
    cycle();
    cycle();
    n_checks++; if (o_iw !== 1'b0 || o_pc !== 32'h40 || o_inst !== memf(32'h40)) begin
      n_fail++; $display("FAIL rwait_deliver: got iw=%0b pc=%h inst=%h want 0 40 %h", o_iw, o_pc, o_inst, memf(32'h40));
    end
  endtask

  task automatic test_redirect_fetch();
    lat = 1;
    do_reset(4);
    set_redir(32'h20);
    cycle();
    n_checks++; if (o_req !== 1'b0) begin n_fail++; $display("FAIL rfetch_idle_req: got %0b want 0", o_req); end
    set_redir(32'h80);
    cycle();
    n_checks++; if (o_req !== 1'b0 || o_addr !== 32'h20) begin n_fail++; $display("FAIL rfetch_suppress: got req=%0b addr=%h want req=0 addr=20", o_req, o_addr); end
    clr_redir();
    cycle();
    n_checks++; if (o_req !== 1'b1 || o_addr !== 32'h80) begin n_fail++; $display("FAIL rfetch_target: got req=%0b addr=%h want req=1 addr=80", o_req, o_addr); end
  endtask

  task automatic test_redirect_hold();
    cycle();
    set_redir(32'h100);
    stall = 1'b0; bubble = 1'b0;
    cycle();
    clr_redir();
    n_checks++; if (o_iw !== 1'b0 || o_pc !== 32'h80 || o_inst !== memf(32'h80)) begin
      n_fail++; $display("FAIL rhold_present: got iw=%0b pc=%h inst=%h want 0 80 %h", o_iw, o_pc, o_inst, memf(32'h80));
    end
    n_checks++; if (o_req !== 1'b0) begin n_fail++; $display("FAIL rhold_no_req: got %0b want 0", o_req); end
    cycle();
    n_checks++; if (o_iw !== 1'b1 || o_inst !== NOP || o_pc !== 32'h80) begin
      n_fail++; $display("FAIL rhold_discard: got iw=%0b inst=%h pc=%h want 1 %h 80", o_iw, o_inst, o_pc, NOP);
    end
    n_checks++; if (o_req !== 1'b1 || o_addr !== 32'h100) begin n_fail++; $display("FAIL rhold_target: got req=%0b addr=%h want req=1 addr=100", o_req, o_addr); end
  endtask

  task automatic test_wrap();
    cycle();
    set_redir(32'hFFFF_FFFF);
    cycle();
    clr_redir();
    cycle();
    n_checks++; if (o_req !== 1'b1 || o_addr !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_req: got req=%0b addr=%h want req=1 addr=ffffffff", o_req, o_addr); end
    cycle();
    cycle();
    n_checks++; if (o_iw !== 1'b0 || o_pc !== 32'hFFFF_FFFF || o_inst !== memf(32'hFFFF_FFFF)) begin
      n_fail++; $display("FAIL wrap_pc: got iw=%0b pc=%h inst=%h want 0 ffffffff %h", o_iw, o_pc, o_inst, memf(32'hFFFF_FFFF));
    end
    n_checks++; if (o_req !== 1'b1 || o_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_next: got req=%0b addr=%h want req=1 addr=0", o_req, o_addr); end
  endtask

  task automatic test_reset_mid_wait();
    bit ok;
    lat = 3;
    wait_req(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rstwait_reach: got no request want one"); end
    rst_n = 1'b0;
    cycle();
    n_checks++; if (o_req !== 1'b0 || o_iw !== 1'b1 || o_inst !== NOP || o_pc !== 32'h0) begin
      n_fail++; $display("FAIL rstwait_async: got req=%0b iw=%0b inst=%h pc=%h want 0 1 %h 0", o_req, o_iw, o_inst, o_pc, NOP);
    end
    cycle();
    rst_n = 1'b1;
    lat = 1;
    cycle();
    n_checks++; if (!o_rv || o_iw !== 1'b1 || o_req !== 1'b0) begin
      n_fail++; $display("FAIL rstwait_idle: got rvalid=%0b iw=%0b req=%0b want 1 1 0", o_rv, o_iw, o_req);
    end
    cycle();
    n_checks++; if (o_req !== 1'b1 || o_addr !== 32'h0 || o_iw !== 1'b1) begin
      n_fail++; $display("FAIL rstwait_fetch: got req=%0b addr=%h iw=%0b want 1 0 1", o_req, o_addr, o_iw);
    end
    cycle();
    cycle();
    n_checks++; if (o_iw !== 1'b0 || o_pc !== 32'h0 || o_inst !== memf(32'h0)) begin
      n_fail++; $display("FAIL rstwait_deliver: got iw=%0b pc=%h inst=%h want 0 0 %h", o_iw, o_pc, o_inst, memf(32'h0));
    end
  endtask

  // Reference: the delivered stream is consecutive PCs, restarting at each redirect target.
  task automatic test_random();
    logic [31:0] exp_next = 32'h0;
    logic [31:0] last_pc = 32'h0;
    int delivered = 0;
    bit redir, adv;
    do_reset(5);
    for (int i = 0; i < 3000; i++) begin
      stall          = ($urandom_range(0, 3) == 0);
      bubble         = ($urandom_range(0, 5) == 0);
      flush          = ($urandom_range(0, 11) == 0);
      redirect_valid = ($urandom_range(0, 2) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3)) : $urandom;
      lat            = $urandom_range(1, 4);
      cycle();
      redir = flush && redirect_valid;
      adv   = !stall && !bubble;
      n_checks++; if (o_overlap) begin n_fail++; $display("FAIL rnd_outstanding i%0d: got second request addr=%h want none", i, o_addr); end
      if (!o_iw) begin
        n_checks++; if (o_pc !== exp_next) begin n_fail++; $display("FAIL rnd_pc i%0d: got %h want %h", i, o_pc, exp_next); end
        n_checks++; if (o_inst !== memf(exp_next)) begin n_fail++; $display("FAIL rnd_inst i%0d: got %h want %h", i, o_inst, memf(exp_next)); end
        last_pc = exp_next;
        if (adv && !redir) begin
          exp_next = exp_next + 32'd1;
          delivered++;
        end
      end else begin
        n_checks++; if (o_inst !== NOP || o_pc !== last_pc) begin
          n_fail++; $display("FAIL rnd_idle i%0d: got inst=%h pc=%h want %h %h", i, o_inst, o_pc, NOP, last_pc);
        end
      end
      if (redir) begin
        n_checks++; if (o_req !== 1'b0) begin n_fail++; $display("FAIL rnd_redir_req i%0d: got %0b want 0", i, o_req); end
        exp_next = redirect_pc;
      end else if (o_req) begin
        n_checks++; if (o_addr !== exp_next) begin n_fail++; $display("FAIL rnd_addr i%0d: got %h want %h", i, o_addr, exp_next); end
      end
    end
    clr_redir();
    stall = 1'b0; bubble = 1'b0;
    n_checks++; if (delivered < 100) begin n_fail++; $display("FAIL rnd_progress: got %0d delivered want >= 100", delivered); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_stall();
    test_redirect_wait();
    test_redirect_fetch();
    test_redirect_hold();
    test_wrap();
    test_reset_mid_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage that sits directly upstream of the fetch/decode pipeline register.
- Owns the PC and drives a single-outstanding-request instruction-memory handshake.
- Presents one instruction/PC pair per fetch to the F/D register, which consumes instruction_o and pc_o as its instruction_fd and PC_r_fd inputs.
- Raises IDLE_WAIT whenever no valid instruction is available, so the F/D register inserts `kNOP.
- Accepts branch/jump redirects from downstream together with flush.

Parameters:
PC_W, 32, PC and instruction-memory address width.
IW, 32, instruction width.
PC_INC, 1, sequential PC increment (word-addressed memory).
RESET_PC, 0, PC value loaded on reset.

Ports:
clk  input  1  single clock; all state on posedge.
rst_n  input  1  asynchronous active-low reset.
stall  input  1  downstream hold; same signal that drives the F/D register.
bubble  input  1  downstream bubble; treated identically to stall for advance.
flush  input  1  pipeline flush; qualifies redirect.
redirect_valid  input  1  redirect request; effective only when flush=1.
redirect_pc  input  PC_W  redirect target.
imem_req  output  1  memory request strobe, one cycle per request.
imem_addr  output  PC_W  request address, valid when imem_req=1.
imem_rvalid  input  1  response valid, earliest one cycle after the request.
imem_rdata  input  IW  response instruction.
instruction_o  output  IW  instruction to the F/D register; `kNOP when not valid.
pc_o  output  PC_W  PC of instruction_o; holds the last valid PC otherwise.
IDLE_WAIT  output  1  1 when instruction_o is not a valid fetched instruction.

Behaviour:
- advance = ~stall & ~bubble. redir = flush & redirect_valid.
- redir has the highest priority in every state.
- Registers: state, fetch_pc, inst_q, pc_q.
- Reset (async, rst_n=0):
  - state=RST_IDLE, fetch_pc=RESET_PC, inst_q=`kNOP, pc_q=RESET_PC.
  - imem_req=0, IDLE_WAIT=1, instruction_o=`kNOP, pc_o=RESET_PC.
  - Any response arriving in RST_IDLE is ignored.
- RST_IDLE: unconditionally moves to FETCH on the next edge. A redirect in this cycle loads fetch_pc.
- FETCH:
  - imem_req=1, imem_addr=fetch_pc; next state WAIT.
  - If redir: imem_req is combinationally forced to 0, fetch_pc<=redirect_pc, state stays FETCH.
- WAIT:
  - Stays until imem_rvalid.
  - On imem_rvalid: inst_q<=imem_rdata, pc_q<=fetch_pc, fetch_pc<=fetch_pc+PC_INC (mod 2^PC_W), go HOLD.
  - redir with imem_rvalid: data discarded, fetch_pc<=redirect_pc, go FETCH.
  - redir without imem_rvalid: fetch_pc<=redirect_pc, go DRAIN.
- DRAIN:
  - Waits for the stale response and discards it, then goes FETCH.
  - A redirect here updates fetch_pc and stays in DRAIN unless imem_rvalid is present the same cycle, in which case go FETCH.
- HOLD:
  - instruction_o=inst_q, pc_o=pc_q, IDLE_WAIT=0.
  - If advance and not redir: imem_req=1, imem_addr=fetch_pc, go WAIT (back-to-back refill; output consumed this edge).
  - If not advance: hold all outputs.
  - If redir: no request, discard inst_q (instruction_o becomes `kNOP), fetch_pc<=redirect_pc, go FETCH.
- In RST_IDLE/FETCH/WAIT/DRAIN:
  - IDLE_WAIT=1, instruction_o=`kNOP, pc_o=pc_q.
  - stall/bubble have no effect; the memory response is always captured.
- Never more than one request outstanding. imem_req is never asserted in WAIT/DRAIN/RST_IDLE.
- Throughput: one instruction per 2 cycles with 1-cycle memory latency.
- PC wrap: all-ones + PC_INC wraps to 0 silently.

Test Plan:
- Reset release, RESET_PC=0, memory latency 1, no stall:
  - imem_req at cycles 1, 3, 5 with addr 0, 1, 2.
  - IDLE_WAIT low in cycles 3, 5, 7 with pc_o 0, 1, 2.
- stall=1 for 4 cycles while in HOLD at pc 5:
  - instruction_o/pc_o=5 constant, imem_req=0 throughout.
  - After stall drops, imem_req with addr 6 on the next cycle.
- flush+redirect_valid, redirect_pc=0x40, while in WAIT with response at +3 cycles:
  - Stale data never appears on instruction_o.
  - Next imem_req addr=0x40 on the cycle after the stale rvalid.
- Redirect in FETCH (target 0x80):
  - imem_req=0 that cycle, imem_req addr=0x80 the next cycle.
- Redirect in HOLD with advance=1 in the same cycle:
  - No request that cycle, instruction_o=`kNOP next cycle, FETCH at the target.
- fetch_pc=0xFFFFFFFF fetched:
  - pc_o=0xFFFFFFFF, next imem_addr=0.
- rst_n asserted mid-WAIT:
  - Outputs immediately at reset values; a later rvalid in RST_IDLE is ignored.
